// File: rtl/wb_periph_mux_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_periph_mux_if
// Purpose  : Caravel-side and peripheral-side wishbone signals of wb_periph_mux.
// Revision : 1.0 - initial release
// ============================================================================
interface wb_periph_mux_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        s_cyc_o;
  logic [2:0]  s_stb_o;
  logic        s_we_o;
  logic [3:0]  s_sel_o;
  logic [15:0] s_adr_o;
  logic [31:0] s_dat_o;
  logic [95:0] s_dat_i;
  logic [2:0]  s_ack_i;

  // The mux itself: slave to the management SoC, master to the peripherals.
  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  s_dat_i, s_ack_i,
    output wbs_ack_o, wbs_dat_o,
    output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output s_dat_i, s_ack_i,
    input  wbs_ack_o, wbs_dat_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o
  );
endinterface
`default_nettype wire

// File: rtl/wb_periph_mux.sv
`default_nettype none
// ============================================================================
// Module   : wb_periph_mux
// Purpose  : Decodes three 4 KB windows and forwards one wishbone transaction
//            at a time; WB_PERIPH_MUX_TIMEOUT_EN enables the hung-slave timeout.
// Revision : 1.0 - initial release
// ============================================================================
module wb_periph_mux #(
  parameter logic [19:0] S0_BASE  = 20'h30001,
  parameter logic [19:0] S1_BASE  = 20'h30002,
  parameter logic [19:0] S2_BASE  = 20'h30005,
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_DEAD
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  wb_periph_mux_if.slave bus,
  input  logic           clr_timeout_i,
  output logic           timeout_o
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic        ack_nx;
  logic [31:0] rdat_nx;
  logic        cyc_nx;
  logic [2:0]  stb_nx;
  logic        we_nx;
  logic [3:0]  sel_nx;
  logic [15:0] adr_nx;
  logic [31:0] wdat_nx;
  logic [2:0]  hit;
  logic [2:0]  hit_oh;
  logic        sel_ack;
  logic [31:0] sel_rdat;
  logic        expired;
  logic        to_evt;
  logic        unused_bits;

  assign hit = {bus.wbs_adr_i[31:12] == S2_BASE,
                bus.wbs_adr_i[31:12] == S1_BASE,
                bus.wbs_adr_i[31:12] == S0_BASE};

  // Lowest slave wins should two bases ever be configured identically.
  always_comb begin
    hit_oh = 3'b000;
    if (hit[0])      hit_oh = 3'b001;
    else if (hit[1]) hit_oh = 3'b010;
    else if (hit[2]) hit_oh = 3'b100;
  end

  assign sel_ack = |(bus.s_ack_i & bus.s_stb_o);

  always_comb begin
    sel_rdat = 32'h0;
    if (bus.s_stb_o[0])      sel_rdat = bus.s_dat_i[31:0];
    else if (bus.s_stb_o[1]) sel_rdat = bus.s_dat_i[63:32];
    else if (bus.s_stb_o[2]) sel_rdat = bus.s_dat_i[95:64];
  end

  always_comb begin
    state_nx = state;
    ack_nx   = 1'b0;
    rdat_nx  = bus.wbs_dat_o;
    cyc_nx   = bus.s_cyc_o;
    stb_nx   = bus.s_stb_o;
    we_nx    = bus.s_we_o;
    sel_nx   = bus.s_sel_o;
    adr_nx   = bus.s_adr_o;
    wdat_nx  = bus.s_dat_o;
    to_evt   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.wbs_cyc_i && bus.wbs_stb_i) begin
          if (|hit) begin
            we_nx    = bus.wbs_we_i;
            sel_nx   = bus.wbs_sel_i;
            adr_nx   = {8'h00, bus.wbs_adr_i[7:0]};
            wdat_nx  = bus.wbs_dat_i;
            stb_nx   = hit_oh;
            cyc_nx   = 1'b1;
            state_nx = WAIT;
          end else begin
            rdat_nx  = 32'h0;
            ack_nx   = 1'b1;
            state_nx = RESP;
          end
        end
      end
      WAIT: begin
        // A master that has abandoned the cycle gets no response at all.
        if (!bus.wbs_cyc_i) begin
          cyc_nx   = 1'b0;
          stb_nx   = 3'b000;
          state_nx = IDLE;
        end else if (sel_ack) begin
          rdat_nx  = bus.s_we_o ? 32'h0 : sel_rdat;
          ack_nx   = 1'b1;
          cyc_nx   = 1'b0;
          stb_nx   = 3'b000;
          state_nx = RESP;
        end else if (expired) begin
          rdat_nx  = ERR_DATA;
          to_evt   = 1'b1;
          ack_nx   = 1'b1;
          cyc_nx   = 1'b0;
          stb_nx   = 3'b000;
          state_nx = RESP;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state         <= IDLE;
      bus.wbs_ack_o <= 1'b0;
      bus.wbs_dat_o <= 32'h0;
      bus.s_cyc_o   <= 1'b0;
      bus.s_stb_o   <= 3'b000;
      bus.s_we_o    <= 1'b0;
      bus.s_sel_o   <= 4'h0;
      bus.s_adr_o   <= 16'h0;
      bus.s_dat_o   <= 32'h0;
    end else begin
      state         <= state_nx;
      bus.wbs_ack_o <= ack_nx;
      bus.wbs_dat_o <= rdat_nx;
      bus.s_cyc_o   <= cyc_nx;
      bus.s_stb_o   <= stb_nx;
      bus.s_we_o    <= we_nx;
      bus.s_sel_o   <= sel_nx;
      bus.s_adr_o   <= adr_nx;
      bus.s_dat_o   <= wdat_nx;
    end
  end

`ifdef WB_PERIPH_MUX_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wait_cnt;

  assign expired = (wait_cnt == CW'(TIMEOUT - 1));

  // Cleared whenever not waiting, so every WAIT entry starts from zero.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)           wait_cnt <= '0;
    else if (state != WAIT) wait_cnt <= '0;
    else if (!expired)      wait_cnt <= wait_cnt + CW'(1);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)           timeout_o <= 1'b0;
    else if (to_evt)        timeout_o <= 1'b1;
    else if (clr_timeout_i) timeout_o <= 1'b0;
  end

  assign unused_bits = ^bus.wbs_adr_i[11:8];
`else
  assign expired     = 1'b0;
  assign timeout_o   = 1'b0;
  assign unused_bits = ^{bus.wbs_adr_i[11:8], to_evt, clr_timeout_i, TIMEOUT};
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_periph_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_periph_mux
// Purpose  : Self-checking bench for wb_periph_mux: vector table, corner-case
//            sequences and randomized transactions against a transaction model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_periph_mux;
  localparam int TMO = 8;
`ifdef WB_PERIPH_MUX_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] wd;
    logic [3:0]  sel;
    int          dly;      // slave acks on its dly-th strobed cycle, 0 = never
    logic [31:0] rd;
    bit          decoy;    // other slaves ack throughout the wait
    int          exp_lat;
    logic [31:0] exp_dat;
    logic [2:0]  exp_stb;
    bit          exp_to;
  } vec_t;

  typedef struct {
    int          lat;
    logic [31:0] dat;
    logic [2:0]  stb;
    logic [15:0] sadr;
    logic        swe;
    logic [3:0]  ssel;
    logic [31:0] sdat;
    bit          unstable;
    logic        ack_after;
    logic        to;
  } obs_t;

  typedef struct {
    int          lat;
    logic [31:0] dat;
    logic [2:0]  stb;
    bit          to;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic clr;
  logic timeout;
  int   total = 0;
  int   bad   = 0;
  bit   flag_model;

  wb_periph_mux_if bus ();

  wb_periph_mux #(.TIMEOUT(TMO)) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .bus           (bus),
    .clr_timeout_i (clr),
    .timeout_o     (timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int slave_of(input logic [31:0] adr);
    case (adr[31:12])
      20'h30001: return 0;
      20'h30002: return 1;
      20'h30005: return 2;
      default:   return -1;
    endcase
  endfunction

  function automatic exp_t model(input vec_t v, input bit flag_in);
    exp_t e;
    int   s;
    s    = slave_of(v.adr);
    e.to = flag_in;
    if (s < 0) begin
      e.lat = 1; e.dat = 32'h0; e.stb = 3'b000;
    end else if (v.dly == 0) begin
      e.lat = TMO + 1; e.dat = 32'hDEAD_DEAD; e.stb = 3'(1 << s); e.to = 1'b1;
    end else begin
      e.lat = v.dly + 1; e.dat = v.we ? 32'h0 : v.rd; e.stb = 3'(1 << s);
    end
    return e;
  endfunction

  function automatic logic [95:0] all_outs();
    return {5'b0, bus.wbs_ack_o, bus.wbs_dat_o, bus.s_cyc_o, bus.s_stb_o, bus.s_we_o,
            bus.s_sel_o, bus.s_adr_o, bus.s_dat_o, timeout};
  endfunction

  task automatic drive_req(input vec_t v);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = v.we;
    bus.wbs_sel_i = v.sel;
    bus.wbs_adr_i = v.adr;
    bus.wbs_dat_i = v.wd;
  endtask

  task automatic drop_req();
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.s_ack_i   = 3'b000;
  endtask

  task automatic run_txn(input vec_t v, input bit clr_hold, output obs_t o);
    int tgt;
    int n;
    tgt = slave_of(v.adr);
    o   = '{lat: -1, default: 0};
    n   = 0;
    bus.s_dat_i = {3{~v.rd}};
    if (tgt >= 0) bus.s_dat_i[32*tgt +: 32] = v.rd;
    clr = clr_hold;
    drive_req(v);
    for (int c = 1; c <= 300; c++) begin
      tick();
      if (bus.wbs_ack_o) begin
        o.lat = c;
        o.dat = bus.wbs_dat_o;
        break;
      end
      if (bus.s_stb_o != 3'b000) begin
        n++;
        if (n == 1) begin
          o.stb = bus.s_stb_o; o.sadr = bus.s_adr_o; o.swe = bus.s_we_o;
          o.ssel = bus.s_sel_o; o.sdat = bus.s_dat_o;
        end else if ({bus.s_stb_o, bus.s_adr_o, bus.s_we_o, bus.s_sel_o, bus.s_dat_o, bus.s_cyc_o}
                     != {o.stb, o.sadr, o.swe, o.ssel, o.sdat, 1'b1}) begin
          o.unstable = 1'b1;
        end
      end
      bus.s_ack_i = 3'b000;
      if (bus.s_stb_o != 3'b000 && tgt >= 0) begin
        if (v.decoy) bus.s_ack_i = ~(3'b001 << tgt);
        if (n == v.dly) bus.s_ack_i[tgt] = 1'b1;
      end
    end
    drop_req();
    clr = 1'b0;
    tick();
    o.ack_after = bus.wbs_ack_o;
    o.to        = timeout;
  endtask

  task automatic check_txn(input string name, input vec_t v, input obs_t o, input exp_t e);
    check({name, "_lat"}, 96'(o.lat), 96'(e.lat));
    check({name, "_dat"}, 96'(o.dat), 96'(e.dat));
    check({name, "_stb"}, 96'(o.stb), 96'(e.stb));
    if (e.stb != 3'b000) begin
      check({name, "_latch"}, 96'({o.sadr, o.swe, o.ssel, o.sdat}),
            96'({8'h00, v.adr[7:0], v.we, v.sel, v.wd}));
      check({name, "_stable"}, 96'(o.unstable), 96'(0));
    end
    check({name, "_ack1cyc"}, 96'(o.ack_after), 96'(0));
    check({name, "_tmo"}, 96'(o.to), 96'(e.to));
  endtask

  initial begin
    vec_t tbl[$];
    vec_t v;
    obs_t o;
    exp_t e;
    logic seen_ack;
    logic [19:0] hi;

    //         adr           we   wd            sel    dly rd            dcy lat dat           stb     to
    tbl.push_back('{32'h3000_5004, 1'b0, 32'h0,        4'hF,  3, 32'h1234_5678, 0, 4, 32'h1234_5678, 3'b100, 0});
    tbl.push_back('{32'h3000_1008, 1'b1, 32'h0000_00FF, 4'h3, 3, 32'hAAAA_5555, 1, 4, 32'h0,         3'b001, 0});
    tbl.push_back('{32'h3000_9000, 1'b0, 32'h0,        4'hF,  2, 32'h5A5A_5A5A, 0, 1, 32'h0,         3'b000, 0});
    tbl.push_back('{32'h3000_20FC, 1'b0, 32'h0,        4'hF,  1, 32'hCAFE_F00D, 1, 2, 32'hCAFE_F00D, 3'b010, 0});
    tbl.push_back('{32'h4000_1000, 1'b1, 32'h1111_2222, 4'hF, 1, 32'h0,         0, 1, 32'h0,         3'b000, 0});
    tbl.push_back('{32'h3000_5FFF, 1'b0, 32'h0,        4'h1,  6, 32'h8765_4321, 1, 7, 32'h8765_4321, 3'b100, 0});
`ifdef WB_PERIPH_MUX_TIMEOUT_EN
    tbl.push_back('{32'h3000_2010, 1'b0, 32'h0,        4'hF,  0, 32'h0,         0, TMO + 1, 32'hDEAD_DEAD, 3'b010, 1});
`endif

    rst = 1'b1; clr = 1'b0;
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0; bus.wbs_sel_i = 4'h0;
    bus.wbs_adr_i = 32'h0; bus.wbs_dat_i = 32'h0; bus.s_dat_i = 96'h0; bus.s_ack_i = 3'b000;
    #12;
    check("reset_outputs", all_outs(), 96'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    flag_model = 1'b0;

    foreach (tbl[i]) begin
      run_txn(tbl[i], 1'b0, o);
      e = '{lat: tbl[i].exp_lat, dat: tbl[i].exp_dat, stb: tbl[i].exp_stb, to: tbl[i].exp_to};
      check_txn($sformatf("tbl%0d", i), tbl[i], o, e);
      flag_model = tbl[i].exp_to;
    end

    // Sticky flag survives until cleared; a timeout coinciding with clear sets it.
    check("tmo_before_clr", 96'(timeout), 96'(flag_model));
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("tmo_cleared", 96'(timeout), 96'(0));
    flag_model = 1'b0;
`ifdef WB_PERIPH_MUX_TIMEOUT_EN
    v = '{32'h3000_1040, 1'b0, 32'h0, 4'hF, 0, 32'h0, 0, 0, 32'h0, 3'b000, 0};
    run_txn(v, 1'b1, o);
    check_txn("set_wins", v, o, model(v, 1'b0));
    flag_model = 1'b1;
`endif

    // Abort: master drops cyc while the slave is still pending.
    v = '{32'h3000_2000, 1'b0, 32'h0, 4'hF, 0, 32'h0, 0, 0, 32'h0, 3'b000, 0};
    drive_req(v);
    tick(); tick(); tick();
    check("abort_pending_stb", 96'({bus.s_cyc_o, bus.s_stb_o}), 96'({1'b1, 3'b010}));
    drop_req();
    tick();
    check("abort_strobes", 96'({bus.s_cyc_o, bus.s_stb_o}), 96'(0));
    seen_ack = bus.wbs_ack_o;
    for (int k = 0; k < 3; k++) begin
      tick();
      seen_ack = seen_ack | bus.wbs_ack_o;
    end
    check("abort_no_ack", 96'(seen_ack), 96'(0));
    v = '{32'h3000_1004, 1'b0, 32'h0, 4'hF, 2, 32'h0BAD_CAFE, 0, 0, 32'h0, 3'b000, 0};
    run_txn(v, 1'b0, o);
    check_txn("after_abort", v, o, model(v, flag_model));

    // Asynchronous reset in the middle of a wait.
    v = '{32'h3000_10A5, 1'b1, 32'hFEED_BEEF, 4'hC, 0, 32'h0, 0, 0, 32'h0, 3'b000, 0};
    drive_req(v);
    tick(); tick();
    #3;
    rst = 1'b1;
    #1;
    check("async_reset", all_outs(), 96'h0);
    drop_req();
    #2;
    rst = 1'b0;
    flag_model = 1'b0;
    tick();
    v = '{32'h3000_5010, 1'b0, 32'h0, 4'hF, 1, 32'h7777_1234, 1, 0, 32'h0, 3'b000, 0};
    run_txn(v, 1'b0, o);
    check_txn("after_reset", v, o, model(v, flag_model));

    for (int r = 0; r < 40; r++) begin
      case ($urandom_range(0, 3))
        0: hi = 20'h30001;
        1: hi = 20'h30002;
        2: hi = 20'h30005;
        default: begin
          do hi = 20'($urandom);
          while (hi == 20'h30001 || hi == 20'h30002 || hi == 20'h30005);
        end
      endcase
      v.adr   = {hi, 12'($urandom)};
      v.we    = 1'($urandom);
      v.wd    = $urandom;
      v.sel   = 4'($urandom);
      v.dly   = TO_EN ? int'($urandom_range(0, 6)) : int'($urandom_range(1, 6));
      v.rd    = $urandom;
      v.decoy = 1'($urandom);
      run_txn(v, 1'b0, o);
      e = model(v, flag_model);
      check_txn($sformatf("rnd%0d", r), v, o, e);
      flag_model = e.to;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
